mem_to_axil_bridge: RTL and testbench
=====================================

Name: mem_to_axil_bridge

Overview:
Parametrised bridge from a simple req/gnt memory port (debug module or DMA side) to an AXI4-Lite master.
- Supports up to MAX_OUTSTANDING in-flight transactions, mixed reads and writes.
- Returns responses in order, with error reporting.
- Drives independent AW/W channels.
- Sits between dm_top-style requesters and the SoC AXI-Lite crossbar.

Parameters:
ADDR_W, 32, address width of mem and AXI sides
DATA_W, 32, data width (32 or 64); STRB_W = DATA_W/8 derived
MAX_OUTSTANDING, 4, depth of order-tracking FIFO (power of two, >=1)
AXI_PROT, 3'b000, constant driven on aw_prot/ar_prot
TIMEOUT_CYCLES, 1024, watchdog limit (used only with optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
mem_req_i  in  1  request valid
mem_addr_i  in  ADDR_W  byte address
mem_we_i  in  1  1=write 0=read
mem_wdata_i  in  DATA_W  write data
mem_be_i  in  STRB_W  byte enables
mem_gnt_o  out  1  request accepted this cycle
mem_rsp_valid_o  out  1  response pulse (reads and writes)
mem_rsp_rdata_o  out  DATA_W  read data (0 for writes)
mem_rsp_error_o  out  1  SLVERR/DECERR/timeout
m_aw_addr/aw_prot/aw_valid  out  ADDR_W/3/1 ; m_aw_ready  in  1
m_w_data/w_strb/w_valid  out  DATA_W/STRB_W/1 ; m_w_ready  in  1
m_b_resp  in  2 ; m_b_valid  in  1 ; m_b_ready  out  1
m_ar_addr/ar_prot/ar_valid  out  ADDR_W/3/1 ; m_ar_ready  in  1
m_r_data  in  DATA_W ; m_r_resp  in  2 ; m_r_valid  in  1 ; m_r_ready  out  1

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset state: all valids, mem_gnt_o, mem_rsp_valid_o and mem_rsp_error_o are 0; mem_rsp_rdata_o = 0; FIFO empty; pending flags cleared.
- Reset mid-transaction: in-flight transactions are abandoned with no response. The system resets the slave with the same rst_n.
- Grant: mem_gnt_o = mem_req_i && !fifo_full && !aw_pend && !w_pend && !ar_pend. Combinational; accepted when req && gnt.
- Read accept: latch address; ar_pend=1; push READ into order FIFO. ar_valid is asserted from the next cycle until m_ar_ready.
- Write accept: latch addr/data/strb; aw_pend=1 and w_pend=1; push WRITE into order FIFO.
  - aw_valid and w_valid are asserted from the next cycle.
  - Each drops independently on its own ready. W may complete before AW and vice versa.
- Valid stability: AXI rule holds; valid and payload are held stable until the handshake, never retracted.
- Address-to-response latency: minimum 1 cycle from grant to address valid.
- Response ready: m_b_ready = !empty && head==WRITE; m_r_ready = !empty && head==READ.
  - A response on the non-head channel is back-pressured.
  - Never blocks, because AXI-Lite slaves respond in order per channel.
- Response return: on B or R handshake, pop FIFO. Next cycle mem_rsp_valid_o=1 for one cycle.
  - Read: rdata = m_r_data; write: rdata = 0.
  - error = resp[1].
- Minimum read round trip: grant -> rsp_valid = 3 cycles with zero-wait slave.
- Full: at MAX_OUTSTANDING entries the grant is held low. Same-cycle pop and accept is allowed when full; the pop frees the slot combinationally.
- Simultaneous accept and response: push and pop in the same cycle; count is unchanged.
- FIFO pointers: wrap modulo MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING)+1.

Optional Feature:
MEM_AXIL_TIMEOUT_EN
- Enabled: a counter runs while the FIFO is non-empty and resets on every pop.
- Timeout trigger: at TIMEOUT_CYCLES the head is popped with rsp_valid=1, error=1, rdata=0.
- Drop counters: a per-channel drop counter (read or write) increments. The next late B/R on that channel is accepted (ready forced 1) and discarded, and the drop counter decrements.
- Disabled: no counter and no drop logic; the bridge waits forever.

Decomposition:
- holy_core_pkg: axil_resp_t codes (OKAY, EXOKAY, SLVERR, DECERR) and txn_type_e {TXN_READ, TXN_WRITE}.
- Sub-module axil_txn_fifo: parametrised depth FIFO of txn_type_e with push/pop/full/empty/count.

Test Plan:
1. Read 0x8000_0010, slave returns 0xDEAD_BEEF OKAY with zero wait -> rsp_valid 3 cycles after grant, rdata=0xDEAD_BEEF, error=0.
2. Write 0x1000_0004, data 0x1234_5678, be 4'b0011; slave takes W two cycles before AW -> single B handshake, rsp_valid with rdata=0, error=0; strb seen as 0011.
3. Issue 5 reads with MAX_OUTSTANDING=4 while the slave stalls R -> 5th gnt held low until first R; responses return in issue order.
4. Write then read back-to-back; slave answers B with SLVERR (2'b10) -> write rsp error=1, read rsp error=0; order preserved.
5. Assert rst_n low while ar_valid is high -> all outputs 0 asynchronously; after release the FIFO is empty and a new read completes normally.
6. MEM_AXIL_TIMEOUT_EN with TIMEOUT_CYCLES=16; slave withholds R for 40 cycles -> error rsp at cycle 16; late R is consumed silently with no second rsp_valid.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared types for the memory-port to AXI4-Lite bridge: response codes,
// transaction kinds and the response error decode.
package holy_core_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic {
    TXN_READ  = 1'b0,
    TXN_WRITE = 1'b1
  } txn_type_e;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return (axil_resp_t'(resp) == SLVERR) || (axil_resp_t'(resp) == DECERR);
  endfunction

endpackage

// File: rtl/mem_to_axil_bridge_fifo.sv
// Order-tracking FIFO of transaction kinds; one entry per accepted request,
// popped when its response (or timeout) retires it.
module axil_txn_fifo
  import holy_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  txn_type_e data_i,
  output txn_type_e head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  txn_type_e        mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d  = push_i ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop_i  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= TXN_READ;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_i) mem_q[wptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_to_axil_bridge.sv
// req/gnt memory port to AXI4-Lite master with in-order responses.
// Optional watchdog on the head transaction: define MEM_AXIL_TIMEOUT_EN.
module mem_to_axil_bridge
  import holy_core_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [2:0]  AXI_PROT        = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned STRB_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [STRB_W-1:0] mem_be_i,
  output logic              mem_gnt_o,
  output logic              mem_rsp_valid_o,
  output logic [DATA_W-1:0] mem_rsp_rdata_o,
  output logic              mem_rsp_error_o,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [2:0]        m_aw_prot,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  output logic [DATA_W-1:0] m_w_data,
  output logic [STRB_W-1:0] m_w_strb,
  output logic              m_w_valid,
  input  logic              m_w_ready,
  input  logic [1:0]        m_b_resp,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [2:0]        m_ar_prot,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_valid,
  output logic              m_r_ready
);

  if (MAX_OUTSTANDING < 1 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mem_to_axil_bridge: invalid MAX_OUTSTANDING or TIMEOUT_CYCLES");
  end

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic              ar_pend_q, ar_pend_d, aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic      fifo_full, fifo_empty, fifo_pop, accept;
  txn_type_e fifo_head;
  logic      r_drop, b_drop, r_hs, b_hs, r_pop, b_pop, to_fire;

  axil_txn_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (fifo_pop),
    .data_i  (mem_we_i ? TXN_WRITE : TXN_READ),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Late responses owed to timed-out entries are drained ahead of the head.
  assign m_r_ready = r_drop || (!fifo_empty && fifo_head == TXN_READ);
  assign m_b_ready = b_drop || (!fifo_empty && fifo_head == TXN_WRITE);
  assign r_hs      = m_r_valid && m_r_ready;
  assign b_hs      = m_b_valid && m_b_ready;
  assign r_pop     = r_hs && !r_drop;
  assign b_pop     = b_hs && !b_drop;
  assign fifo_pop  = r_pop || b_pop || to_fire;

  assign mem_gnt_o = mem_req_i && (!fifo_full || fifo_pop) &&
                     !aw_pend_q && !w_pend_q && !ar_pend_q;
  assign accept    = mem_gnt_o;

`ifdef MEM_AXIL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] drop_r_q, drop_r_d, drop_w_q, drop_w_d;

  assign r_drop  = (drop_r_q != '0);
  assign b_drop  = (drop_w_q != '0);
  assign to_fire = !fifo_empty && !r_pop && !b_pop &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = (fifo_pop || fifo_empty) ? '0 : to_cnt_q + 1'b1;
    drop_r_d = drop_r_q + CNT_W'(to_fire && fifo_head == TXN_READ)
                        - CNT_W'(r_hs && r_drop);
    drop_w_d = drop_w_q + CNT_W'(to_fire && fifo_head == TXN_WRITE)
                        - CNT_W'(b_hs && b_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      drop_r_q <= '0;
      drop_w_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      drop_r_q <= drop_r_d;
      drop_w_q <= drop_w_d;
    end
  end
`else
  assign r_drop  = 1'b0;
  assign b_drop  = 1'b0;
  assign to_fire = 1'b0;
`endif

  // One address phase at a time, so AW and AR share the latched address.
  always_comb begin
    ar_pend_d = ar_pend_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    if (ar_pend_q && m_ar_ready) ar_pend_d = 1'b0;
    if (aw_pend_q && m_aw_ready) aw_pend_d = 1'b0;
    if (w_pend_q && m_w_ready)   w_pend_d  = 1'b0;
    if (accept) begin
      addr_d = mem_addr_i;
      if (mem_we_i) begin
        aw_pend_d = 1'b1;
        w_pend_d  = 1'b1;
        wdata_d   = mem_wdata_i;
        strb_d    = mem_be_i;
      end else begin
        ar_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid_d = fifo_pop;
    rsp_rdata_d = r_pop ? m_r_data : '0;
    rsp_error_d = 1'b0;
    if (r_pop)        rsp_error_d = resp_is_error(m_r_resp);
    else if (b_pop)   rsp_error_d = resp_is_error(m_b_resp);
    else if (to_fire) rsp_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_pend_q   <= 1'b0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      ar_pend_q   <= ar_pend_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign m_aw_addr       = addr_q;
  assign m_aw_prot       = AXI_PROT;
  assign m_aw_valid      = aw_pend_q;
  assign m_w_data        = wdata_q;
  assign m_w_strb        = strb_q;
  assign m_w_valid       = w_pend_q;
  assign m_ar_addr       = addr_q;
  assign m_ar_prot       = AXI_PROT;
  assign m_ar_valid      = ar_pend_q;
  assign mem_rsp_valid_o = rsp_valid_q;
  assign mem_rsp_rdata_o = rsp_rdata_q;
  assign mem_rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_mem_to_axil_bridge.sv
// Directed bench for mem_to_axil_bridge; the timeout scenario is compiled in
// only when MEM_AXIL_TIMEOUT_EN is defined.
module tb_mem_to_axil_bridge;

  logic        clk, rst_n;
  logic        mem_req_i, mem_we_i, mem_gnt_o;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rsp_rdata_o;
  logic [3:0]  mem_be_i;
  logic        mem_rsp_valid_o, mem_rsp_error_o;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
  logic [2:0]  m_aw_prot, m_ar_prot;
  logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_b_resp, m_r_resp;
  logic        m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] rd [5];

  mem_to_axil_bridge #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MAX_OUTSTANDING (4),
    .AXI_PROT        (3'b000),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_req_i       (mem_req_i),
    .mem_addr_i      (mem_addr_i),
    .mem_we_i        (mem_we_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_be_i        (mem_be_i),
    .mem_gnt_o       (mem_gnt_o),
    .mem_rsp_valid_o (mem_rsp_valid_o),
    .mem_rsp_rdata_o (mem_rsp_rdata_o),
    .mem_rsp_error_o (mem_rsp_error_o),
    .m_aw_addr       (m_aw_addr),
    .m_aw_prot       (m_aw_prot),
    .m_aw_valid      (m_aw_valid),
    .m_aw_ready      (m_aw_ready),
    .m_w_data        (m_w_data),
    .m_w_strb        (m_w_strb),
    .m_w_valid       (m_w_valid),
    .m_w_ready       (m_w_ready),
    .m_b_resp        (m_b_resp),
    .m_b_valid       (m_b_valid),
    .m_b_ready       (m_b_ready),
    .m_ar_addr       (m_ar_addr),
    .m_ar_prot       (m_ar_prot),
    .m_ar_valid      (m_ar_valid),
    .m_ar_ready      (m_ar_ready),
    .m_r_data        (m_r_data),
    .m_r_resp        (m_r_resp),
    .m_r_valid       (m_r_valid),
    .m_r_ready       (m_r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic issue_read(input logic [31:0] addr, input string tag);
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = addr;
    #1 check({tag, "_gnt"}, mem_gnt_o, 1);
    @(negedge clk);
    mem_req_i = 1'b0;
    check({tag, "_arv"}, m_ar_valid, 1);
    check({tag, "_araddr"}, m_ar_addr, addr);
    m_ar_ready = 1'b1;
    @(negedge clk);
    m_ar_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
    m_aw_ready = 0; m_w_ready = 0; m_b_resp = '0; m_b_valid = 0;
    m_ar_ready = 0; m_r_data = '0; m_r_resp = '0; m_r_valid = 0;
    rd[0] = 32'h1111_0000; rd[1] = 32'h2222_0001; rd[2] = 32'h3333_0002;
    rd[3] = 32'h4444_0003; rd[4] = 32'h5555_0004;

    repeat (2) @(negedge clk);
    check("rst_gnt", mem_gnt_o, 0);
    check("rst_valids", {m_aw_valid, m_w_valid, m_ar_valid}, 0);
    check("rst_rsp", {mem_rsp_valid_o, mem_rsp_error_o}, 0);
    check("rst_rdata", mem_rsp_rdata_o, 0);
    check("rst_readies", {m_b_ready, m_r_ready}, 0);
    rst_n = 1'b1;

    // 1: zero-wait read, response three cycles after grant
    @(negedge clk);
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0010;
    #1 check("t1_gnt", mem_gnt_o, 1);
    @(negedge clk);
    mem_req_i = 0;
    check("t1_arv", m_ar_valid, 1);
    check("t1_araddr", m_ar_addr, 32'h8000_0010);
    check("t1_arprot", m_ar_prot, 0);
    check("t1_rspv_c1", mem_rsp_valid_o, 0);
    m_ar_ready = 1;
    @(negedge clk);
    m_ar_ready = 0;
    check("t1_arv_drop", m_ar_valid, 0);
    m_r_valid = 1; m_r_data = 32'hDEAD_BEEF; m_r_resp = 2'b00;
    #1 check("t1_rready", m_r_ready, 1);
    check("t1_rspv_c2", mem_rsp_valid_o, 0);
    @(negedge clk);
    m_r_valid = 0;
    check("t1_rspv_c3", mem_rsp_valid_o, 1);
    check("t1_rdata", mem_rsp_rdata_o, 32'hDEAD_BEEF);
    check("t1_err", mem_rsp_error_o, 0);
    @(negedge clk);
    check("t1_rspv_pulse", mem_rsp_valid_o, 0);

    // 2: write, W accepted two cycles before AW
    @(negedge clk);
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h1000_0004;
    mem_wdata_i = 32'h1234_5678; mem_be_i = 4'b0011;
    #1 check("t2_gnt", mem_gnt_o, 1);
    @(negedge clk);
    mem_req_i = 0; mem_we_i = 0;
    check("t2_awv", m_aw_valid, 1);
    check("t2_wv", m_w_valid, 1);
    check("t2_awaddr", m_aw_addr, 32'h1000_0004);
    check("t2_wdata", m_w_data, 32'h1234_5678);
    check("t2_wstrb", m_w_strb, 4'b0011);
    m_w_ready = 1;
    @(negedge clk);
    m_w_ready = 0;
    check("t2_wv_drop", m_w_valid, 0);
    check("t2_awv_hold", m_aw_valid, 1);
    mem_req_i = 1; mem_addr_i = 32'h9000_0000;
    #1 check("t2_gnt_blocked", mem_gnt_o, 0);
    mem_req_i = 0;
    @(negedge clk);
    check("t2_awv_hold2", m_aw_valid, 1);
    check("t2_awaddr_hold", m_aw_addr, 32'h1000_0004);
    m_aw_ready = 1;
    @(negedge clk);
    m_aw_ready = 0;
    check("t2_awv_drop", m_aw_valid, 0);
    m_b_valid = 1; m_b_resp = 2'b00;
    #1 check("t2_bready", m_b_ready, 1);
    check("t2_rready_nonhead", m_r_ready, 0);
    @(negedge clk);
    m_b_valid = 0;
    check("t2_rspv", mem_rsp_valid_o, 1);
    check("t2_rdata", mem_rsp_rdata_o, 0);
    check("t2_err", mem_rsp_error_o, 0);

    // 3: five reads against a stalled R channel, depth four
    for (int i = 0; i < 4; i++) issue_read(32'h2000_0000 + 32'(i * 4), $sformatf("t3_rd%0d", i));
    @(negedge clk);
    mem_req_i = 1; mem_addr_i = 32'h2000_0010;
    #1 check("t3_full_gnt", mem_gnt_o, 0);
    check("t3_rready", m_r_ready, 1);
    check("t3_bready_nonhead", m_b_ready, 0);
    @(negedge clk);
    #1 check("t3_full_gnt2", mem_gnt_o, 0);
    m_r_valid = 1; m_r_data = rd[0]; m_r_resp = 2'b00;
    #1 check("t3_pop_gnt", mem_gnt_o, 1);
    @(negedge clk);
    mem_req_i = 0; m_r_valid = 0;
    check("t3_rsp0_v", mem_rsp_valid_o, 1);
    check("t3_rsp0_d", mem_rsp_rdata_o, rd[0]);
    check("t3_rd4_arv", m_ar_valid, 1);
    check("t3_rd4_araddr", m_ar_addr, 32'h2000_0010);
    m_ar_ready = 1;
    @(negedge clk);
    m_ar_ready = 0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      m_r_valid = 1; m_r_data = rd[k];
      #1 check($sformatf("t3_rready%0d", k), m_r_ready, 1);
      @(negedge clk);
      m_r_valid = 0;
      check($sformatf("t3_rsp%0d_v", k), mem_rsp_valid_o, 1);
      check($sformatf("t3_rsp%0d_d", k), mem_rsp_rdata_o, rd[k]);
    end
    @(negedge clk);
    check("t3_idle_rspv", mem_rsp_valid_o, 0);
    check("t3_empty_rready", m_r_ready, 0);

    // 4: write then read back-to-back, B returns SLVERR
    @(negedge clk);
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h3000_0000;
    mem_wdata_i = 32'hA5A5_5A5A; mem_be_i = 4'b1111;
    #1 check("t4_wgnt", mem_gnt_o, 1);
    @(negedge clk);
    mem_req_i = 0; mem_we_i = 0;
    m_aw_ready = 1; m_w_ready = 1;
    @(negedge clk);
    m_aw_ready = 0; m_w_ready = 0;
    mem_req_i = 1; mem_addr_i = 32'h3000_0000;
    m_b_valid = 1; m_b_resp = 2'b10;
    #1 check("t4_rgnt", mem_gnt_o, 1);
    check("t4_bready", m_b_ready, 1);
    @(negedge clk);
    mem_req_i = 0; m_b_valid = 0; m_b_resp = 2'b00;
    check("t4_wrsp_v", mem_rsp_valid_o, 1);
    check("t4_wrsp_err", mem_rsp_error_o, 1);
    check("t4_wrsp_d", mem_rsp_rdata_o, 0);
    check("t4_arv", m_ar_valid, 1);
    m_ar_ready = 1;
    @(negedge clk);
    m_ar_ready = 0;
    m_r_valid = 1; m_r_data = 32'hCAFE_F00D; m_r_resp = 2'b00;
    #1 check("t4_bready_nonhead", m_b_ready, 0);
    @(negedge clk);
    m_r_valid = 0;
    check("t4_rrsp_v", mem_rsp_valid_o, 1);
    check("t4_rrsp_err", mem_rsp_error_o, 0);
    check("t4_rrsp_d", mem_rsp_rdata_o, 32'hCAFE_F00D);

    // 5: reset while AR is pending
    @(negedge clk);
    mem_req_i = 1; mem_addr_i = 32'h4000_0000;
    #1 check("t5_gnt", mem_gnt_o, 1);
    @(negedge clk);
    mem_req_i = 0;
    check("t5_arv", m_ar_valid, 1);
    #2 rst_n = 0;
    #1 check("t5_arv_rst", m_ar_valid, 0);
    check("t5_rspv_rst", mem_rsp_valid_o, 0);
    check("t5_rready_rst", m_r_ready, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_req_i = 1; mem_addr_i = 32'h4000_0008;
    #1 check("t5_gnt2", mem_gnt_o, 1);
    @(negedge clk);
    mem_req_i = 0;
    check("t5_araddr2", m_ar_addr, 32'h4000_0008);
    m_ar_ready = 1;
    @(negedge clk);
    m_ar_ready = 0;
    m_r_valid = 1; m_r_data = 32'h0000_5A5A; m_r_resp = 2'b11;
    @(negedge clk);
    m_r_valid = 0; m_r_resp = 2'b00;
    check("t5_rsp_v", mem_rsp_valid_o, 1);
    check("t5_rsp_d", mem_rsp_rdata_o, 32'h0000_5A5A);
    check("t5_rsp_decerr", mem_rsp_error_o, 1);

`ifdef MEM_AXIL_TIMEOUT_EN
    // 6: R withheld for 40 cycles; watchdog retires the read at 16
    begin
      int unsigned first_c, n_rsp;
      logic        t_err;
      logic [31:0] t_data;
      first_c = 0; n_rsp = 0; t_err = 0; t_data = '1;
      @(negedge clk);
      mem_req_i = 1; mem_addr_i = 32'h5000_0000;
      #1 check("t6_gnt", mem_gnt_o, 1);
      for (int c = 1; c <= 45; c++) begin
        @(negedge clk);
        mem_req_i = 0; m_r_valid = 0;
        m_ar_ready = (c == 1);
        if (mem_rsp_valid_o) begin
          n_rsp++;
          if (first_c == 0) begin
            first_c = c; t_err = mem_rsp_error_o; t_data = mem_rsp_rdata_o;
          end
        end
        if (c == 40) begin
          m_r_valid = 1; m_r_data = 32'h0BAD_0BAD;
          #1 check("t6_late_rready", m_r_ready, 1);
        end
      end
      check("t6_rsp_cycle", first_c, 17);
      check("t6_rsp_count", n_rsp, 1);
      check("t6_rsp_err", t_err, 1);
      check("t6_rsp_data", t_data, 0);
      check("t6_drained_rready", m_r_ready, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
